// File: rtl/vga_write_buffer_pkg.sv
// Shared types for the VGA write buffer: bus widths, drain FSM encoding and the
// queued pixel-write entry.
package vga_write_buffer_pkg;

    localparam int VGA_ADDR_W = 19;
    localparam int VGA_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_YIELD = 2'd2
    } vga_wb_state_e;

    typedef struct packed {
        logic [VGA_ADDR_W-1:0] addr;
        logic [VGA_DATA_W-1:0] data;
    } vga_wb_entry_t;

    function automatic vga_wb_entry_t vga_wb_pack(
        input logic [VGA_ADDR_W-1:0] addr,
        input logic [VGA_DATA_W-1:0] data
    );
        vga_wb_entry_t e;
        e.addr = addr;
        e.data = data;
        return e;
    endfunction

endpackage

// File: rtl/vga_wbuf_fifo.sv
// Pixel-write FIFO: storage, wrap-around pointers, occupancy and a registered
// copy of the head entry that holds its last value once the queue drains.
module vga_wbuf_fifo
    import vga_write_buffer_pkg::*;
#(
    parameter int  DEPTH = 8,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clock_i,
    input  logic          reset_ni,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          coal_i,
    input  vga_wb_entry_t entry_i,
    output vga_wb_entry_t head_o,
    output vga_wb_entry_t tail_o,
    output logic [CW-1:0] count_o,
    output logic [CW-1:0] count_next_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] tail_idx_s, wr_idx_s;
    logic [CW-1:0] count_q, count_d;
    vga_wb_entry_t head_q, head_d;
    vga_wb_entry_t mem_q [DEPTH];

    // Next pointers, occupancy and the entry that will sit at the head after the edge
    always_comb begin
        tail_idx_s = wr_ptr_q - PW'(1);
        wr_idx_s   = wr_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        head_d     = head_q;
        if (coal_i) wr_idx_s = tail_idx_s;
        else        wr_idx_s = wr_ptr_q;
        if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
        else        wr_ptr_d = wr_ptr_q;
        if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
        else        rd_ptr_d = rd_ptr_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // A slot written this cycle that becomes the head must be forwarded from the input
        if (count_d == CW'(0))                                     head_d = head_q;
        else if ((push_i || coal_i) && (wr_idx_s == rd_ptr_d))     head_d = entry_i;
        else                                                       head_d = mem_q[rd_ptr_d];
    end

    // Pointer, occupancy and head registers
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr_q <= PW'(0);
            rd_ptr_q <= PW'(0);
            count_q  <= CW'(0);
            head_q   <= '{addr: 19'd0, data: 8'd0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    // Entry storage
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '{addr: 19'd0, data: 8'd0};
        end else if (push_i || coal_i) begin
            mem_q[wr_idx_s] <= entry_i;
        end
    end

    assign head_o       = head_q;
    assign tail_o       = mem_q[tail_idx_s];
    assign count_o      = count_q;
    assign count_next_o = count_d;
    assign full_o       = (count_q == CW'(DEPTH));
    assign empty_o      = (count_q == CW'(0));

endmodule

// File: rtl/vga_write_buffer.sv
// VGA pixel-write buffer between the MEM stage and the framebuffer write port.
// Define VGA_WRITE_COALESCE_EN to merge back-to-back writes to the same address.
module vga_write_buffer
    import vga_write_buffer_pkg::*;
#(
    parameter int  DEPTH     = 8,
    parameter int  SKID      = 2,
    parameter int  MAX_BURST = 16,
    localparam int CW        = $clog2(DEPTH) + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [VGA_ADDR_W-1:0] wr_addr,
    input  logic [VGA_DATA_W-1:0] wr_data,
    output logic                  stall,
    output logic                  fb_we,
    output logic [VGA_ADDR_W-1:0] fb_addr,
    output logic [VGA_DATA_W-1:0] fb_data,
    input  logic                  fb_ready,
    output logic [CW-1:0]         count,
    output logic                  overflow
);

    localparam int BW = $clog2(MAX_BURST + 1);

    vga_wb_state_e state_q, state_d;
    logic [BW-1:0] burst_q, burst_d;
    logic          fb_we_q, fb_we_d;
    logic          stall_q, stall_d;
    logic          overflow_q, overflow_d;
    logic          pop_s, push_s, coal_s, drop_s, full_s, empty_s;
    logic [CW-1:0] count_s, count_next_s;
    vga_wb_entry_t head_s, tail_s, entry_s;

    assign entry_s = vga_wb_pack(wr_addr, wr_data);
    assign pop_s   = fb_we_q && fb_ready;

`ifdef VGA_WRITE_COALESCE_EN
    // The newest entry cannot absorb the write if it is leaving as the head this cycle
    assign coal_s = wr_en && !empty_s && (tail_s.addr == wr_addr) &&
                    !(pop_s && (count_s == CW'(1)));
`else
    logic tail_unused_s;
    assign coal_s        = 1'b0;
    assign tail_unused_s = ^tail_s;
`endif

    assign push_s = wr_en && !coal_s && (!full_s || pop_s);
    assign drop_s = wr_en && !coal_s && full_s && !pop_s;

    vga_wbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock_i      (clock),
        .reset_ni     (reset),
        .push_i       (push_s),
        .pop_i        (pop_s),
        .coal_i       (coal_s),
        .entry_i      (entry_s),
        .head_o       (head_s),
        .tail_o       (tail_s),
        .count_o      (count_s),
        .count_next_o (count_next_s),
        .full_o       (full_s),
        .empty_o      (empty_s)
    );

    // Drain FSM, burst counting and next values of the registered outputs
    always_comb begin
        state_d    = state_q;
        burst_d    = burst_q;
        fb_we_d    = 1'b0;
        stall_d    = 1'b0;
        overflow_d = overflow_q;
        case (state_q)
            ST_IDLE: begin
                burst_d = BW'(0);
                if (count_next_s != CW'(0)) state_d = ST_DRAIN;
                else                        state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                if (pop_s) begin
                    if (burst_q == BW'(MAX_BURST - 1)) begin
                        state_d = ST_YIELD;
                        burst_d = BW'(0);
                    end else if (count_next_s == CW'(0)) begin
                        state_d = ST_IDLE;
                        burst_d = BW'(0);
                    end else begin
                        state_d = ST_DRAIN;
                        burst_d = burst_q + BW'(1);
                    end
                end else begin
                    state_d = ST_DRAIN;
                    burst_d = burst_q;
                end
            end
            ST_YIELD: begin
                burst_d = BW'(0);
                if (count_next_s != CW'(0)) state_d = ST_DRAIN;
                else                        state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                burst_d = BW'(0);
            end
        endcase
        fb_we_d    = (state_d == ST_DRAIN);
        stall_d    = (count_next_s >= CW'(DEPTH - SKID));
        overflow_d = overflow_q | drop_s;
    end

    // Control state and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            burst_q    <= BW'(0);
            fb_we_q    <= 1'b0;
            stall_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            burst_q    <= burst_d;
            fb_we_q    <= fb_we_d;
            stall_q    <= stall_d;
            overflow_q <= overflow_d;
        end
    end

    assign fb_we    = fb_we_q;
    assign stall    = stall_q;
    assign overflow = overflow_q;
    assign fb_addr  = head_s.addr;
    assign fb_data  = head_s.data;
    assign count    = count_s;

endmodule

// File: tb/tb_vga_write_buffer.sv
// Self-checking bench for vga_write_buffer: directed scenarios plus randomized
// traffic checked against a queue-based reference model.
module tb_vga_write_buffer;
    import vga_write_buffer_pkg::*;

    localparam int DEPTH     = 8;
    localparam int SKID      = 2;
    localparam int MAX_BURST = 16;
    localparam int CW        = 4;
    localparam int VW        = 1 + CW + 1 + 1 + VGA_ADDR_W + VGA_DATA_W;

    logic                  clock = 1'b0;
    logic                  reset = 1'b0;
    logic                  wr_en = 1'b0;
    logic [VGA_ADDR_W-1:0] wr_addr = 19'd0;
    logic [VGA_DATA_W-1:0] wr_data = 8'd0;
    logic                  fb_ready = 1'b0;
    logic                  stall, fb_we, overflow;
    logic [VGA_ADDR_W-1:0] fb_addr;
    logic [VGA_DATA_W-1:0] fb_data;
    logic [CW-1:0]         count;

    int n_tests = 0;
    int n_fail  = 0;

    vga_write_buffer #(.DEPTH(DEPTH), .SKID(SKID), .MAX_BURST(MAX_BURST)) dut (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .stall(stall), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
        .fb_ready(fb_ready), .count(count), .overflow(overflow)
    );

    always #5 clock = ~clock;

    // Reference model: the queue of pending writes plus drain-run bookkeeping
    vga_wb_entry_t mq[$];
    int            m_run;
    bit            m_yield, m_we, m_ovf;
    vga_wb_entry_t m_last;

    function automatic logic [VW-1:0] exp_vec();
        return {m_we, CW'(mq.size()), (mq.size() >= DEPTH - SKID), m_ovf, m_last.addr, m_last.data};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {fb_we, count, stall, overflow, fb_addr, fb_data};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_run = 0; m_yield = 1'b0; m_we = 1'b0; m_ovf = 1'b0;
        m_last = '{addr: 19'd0, data: 8'd0};
    endtask

    // Drive one cycle of inputs, advance the model across the edge, return #1 after it
    task automatic step(input bit w, input logic [VGA_ADDR_W-1:0] a,
                        input logic [VGA_DATA_W-1:0] d, input bit r);
        bit pop, coal;
        int sz;
        vga_wb_entry_t e;
        wr_en = w; wr_addr = a; wr_data = d; fb_ready = r;
        pop = m_we && r;
        sz = mq.size();
        coal = 1'b0;
`ifdef VGA_WRITE_COALESCE_EN
        coal = w && (sz > 0) && (mq[sz-1].addr == a) && !(pop && sz == 1);
`endif
        if (coal) begin
            e = mq[sz-1]; e.data = d; mq[sz-1] = e;
        end
        if (pop) void'(mq.pop_front());
        if (w && !coal) begin
            if (sz < DEPTH || pop) mq.push_back(vga_wb_pack(a, d));
            else m_ovf = 1'b1;
        end
        if (pop) begin
            m_run++;
            if (m_run == MAX_BURST) begin m_yield = 1'b1; m_run = 0; end
            else m_yield = 1'b0;
        end else begin
            m_yield = 1'b0;
        end
        if (mq.size() == 0) m_run = 0;
        m_we = (mq.size() > 0) && !m_yield;
        if (mq.size() > 0) m_last = mq[0];
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #12;
        n_tests++;
        if ({fb_we, stall, overflow, count, fb_addr, fb_data} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %h required 0", {fb_we, stall, overflow, count, fb_addr, fb_data});
        end
        reset = 1'b1;
        model_reset();
        @(posedge clock);
        #1;
    endtask

    task automatic test_basic();
        step(1'b1, 19'h00010, 8'h3C, 1'b1);
        n_tests++;
        if ({fb_we, fb_addr, fb_data, count} !== {1'b1, 19'h00010, 8'h3C, 4'd1}) begin
            n_fail++;
            $display("FAIL basic_present: got we=%b a=%h d=%h c=%0d required we=1 a=00010 d=3c c=1", fb_we, fb_addr, fb_data, count);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 19'd0, 8'd0, 1'b1);
            n_tests++;
            if ({fb_we, count, fb_addr, fb_data} !== {1'b0, 4'd0, 19'h00010, 8'h3C}) begin
                n_fail++;
                $display("FAIL basic_idle: got we=%b c=%0d a=%h d=%h required we=0 c=0 a=00010 d=3c", fb_we, count, fb_addr, fb_data);
            end
        end
    endtask

    task automatic test_stall_overflow();
        for (int i = 1; i <= 9; i++) begin
            step(1'b1, 19'h00200 + 19'(i), 8'(8'hA0 + i), 1'b0);
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL fill_model_%0d: got %h required %h", i, obs_vec(), exp_vec());
            end
            n_tests++;
            if ({stall, overflow} !== {(i >= 6), (i >= 9)}) begin
                n_fail++;
                $display("FAIL fill_flags_%0d: got stall=%b ovf=%b required stall=%b ovf=%b", i, stall, overflow, (i >= 6), (i >= 9));
            end
        end
        n_tests++;
        if (count !== 4'd8) begin
            n_fail++;
            $display("FAIL full_count: got %0d required 8", count);
        end
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 19'd0, 8'd0, 1'b1);
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL drain_model_%0d: got %h required %h", i, obs_vec(), exp_vec());
            end
            n_tests++;
            if (stall !== (count >= 4'd6) || overflow !== 1'b1) begin
                n_fail++;
                $display("FAIL drain_flags_%0d: got stall=%b ovf=%b count=%0d required stall=(count>=6) ovf=1", i, stall, overflow, count);
            end
        end
    endtask

    task automatic test_burst_yield();
        logic [29:0] pattern;
        int idx;
        idx = 0;
        pattern = 30'd0;
        for (int k = 0; k < 30; k++) begin
            if (k < 20) step(1'b1, 19'h00400 + 19'(k), 8'(k), 1'b1);
            else        step(1'b0, 19'd0, 8'd0, 1'b1);
            pattern[k] = fb_we;
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL burst_model_%0d: got %h required %h", k, obs_vec(), exp_vec());
            end
            if (fb_we === 1'b1) begin
                n_tests++;
                if (fb_addr !== 19'h00400 + 19'(idx)) begin
                    n_fail++;
                    $display("FAIL burst_order_%0d: got %h required %h", idx, fb_addr, 19'h00400 + 19'(idx));
                end
                idx++;
            end
        end
        n_tests++;
        if (pattern !== 30'h001E_FFFF || idx != 20) begin
            n_fail++;
            $display("FAIL burst_pattern: got %h/%0d writes required 001effff/20 writes", pattern, idx);
        end
    endtask

    task automatic test_coalesce();
        int n_wr;
        logic [7:0] last_d;
        n_wr = 0;
        last_d = 8'd0;
        step(1'b1, 19'h00100, 8'h11, 1'b0);
        step(1'b1, 19'h00100, 8'h22, 1'b0);
        n_tests++;
`ifdef VGA_WRITE_COALESCE_EN
        if (count !== 4'd1) begin
`else
        if (count !== 4'd2) begin
`endif
            n_fail++;
            $display("FAIL coalesce_count: got %0d", count);
        end
        for (int k = 0; k < 5; k++) begin
            if (fb_we === 1'b1) begin n_wr++; last_d = fb_data; end
            step(1'b0, 19'd0, 8'd0, 1'b1);
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL coalesce_model_%0d: got %h required %h", k, obs_vec(), exp_vec());
            end
        end
        n_tests++;
`ifdef VGA_WRITE_COALESCE_EN
        if (n_wr != 1 || last_d !== 8'h22) begin
`else
        if (n_wr != 2 || last_d !== 8'h22) begin
`endif
            n_fail++;
            $display("FAIL coalesce_writes: got %0d writes last=%h", n_wr, last_d);
        end
    endtask

    task automatic test_reset_mid_drain();
        for (int i = 0; i < 5; i++) step(1'b1, 19'h00300 + 19'(i), 8'(i), 1'b0);
        n_tests++;
        if (count !== 4'd5 || fb_we !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: got count=%0d we=%b required 5/1", count, fb_we);
        end
        fb_ready = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        n_tests++;
        if ({fb_we, stall, overflow, count, fb_addr, fb_data} !== 34'd0) begin
            n_fail++;
            $display("FAIL async_reset: got %h required 0", {fb_we, stall, overflow, count, fb_addr, fb_data});
        end
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 19'd0, 8'd0, 1'b1);
            n_tests++;
            if (fb_we !== 1'b0 || obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL post_reset_%0d: got %h required %h", k, obs_vec(), exp_vec());
            end
        end
        step(1'b1, 19'h00055, 8'h5A, 1'b1);
        n_tests++;
        if ({fb_we, fb_addr, fb_data} !== {1'b1, 19'h00055, 8'h5A}) begin
            n_fail++;
            $display("FAIL post_reset_write: got we=%b a=%h d=%h required 1/00055/5a", fb_we, fb_addr, fb_data);
        end
    endtask

    task automatic test_random();
        bit w, r;
        int ready_pct;
        for (int k = 0; k < 800; k++) begin
            ready_pct = ((k / 100) % 2 == 0) ? 85 : 25;
            w = ($urandom_range(0, 99) < 65);
            r = ($urandom_range(0, 99) < ready_pct);
            step(w, 19'h00100 + 19'($urandom_range(0, 3)), 8'($urandom), r);
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_%0d: got %h required %h", k, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_stall_overflow();
        test_burst_yield();
        test_coalesce();
        test_reset_mid_drain();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_write_buffer.md
Name: vga_write_buffer

Overview:
- Sits directly downstream of the pipelined processor's MEM stage, on the VGA write path.
- Captures pixel writes the processor issues (VGA enable, 19-bit pixel address, 8-bit colour) into a small FIFO.
- Drains them to the framebuffer RAM write port whenever that port is granted.
- Back-pressures the processor with a stall when the FIFO nears capacity, so a busy framebuffer never loses pixel writes.

Parameters:
- DEPTH, 8: FIFO entries; power of two, 4..32.
- SKID, 2: free-entry margin at which stall asserts; covers writes already in flight in the processor pipeline.
- MAX_BURST, 16: consecutive framebuffer writes allowed before a forced one-cycle yield.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  pixel write request from the processor MEM stage.
- wr_addr  in  19  pixel address.
- wr_data  in  8  pixel colour.
- stall  out  1  registered; processor must hold its pipeline while high.
- fb_we  out  1  framebuffer write strobe.
- fb_addr  out  19  framebuffer write address (FIFO head).
- fb_data  out  8  framebuffer write data (FIFO head).
- fb_ready  in  1  framebuffer port granted this cycle; a write is accepted when fb_we && fb_ready.
- count  out  log2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky: a write was dropped.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset=0, any time, including mid-drain):
  - FIFO emptied, pointers and burst counter cleared, FSM to IDLE.
  - stall=0, fb_we=0, fb_addr=0, fb_data=0, count=0, overflow=0.
  - In-flight entries are discarded.
- Push:
  - wr_en=1 with count<DEPTH, or count==DEPTH with a pop in the same cycle, enqueues {wr_addr, wr_data} at the clock edge.
  - wr_en=1 with count==DEPTH and no pop drops the write and sets overflow. overflow stays set until reset.
- Pop: occurs when fb_we && fb_ready. The head advances at the edge.
- Simultaneous push and pop: count unchanged; both take effect.
- Latency: a write enqueued into an empty FIFO at edge N is presented on fb_* in cycle N+1. It is written at the first cycle at or after N+1 with fb_ready=1. There is no bypass path.
- fb_addr/fb_data: always show the FIFO head. They hold their last value when empty.
- Ordering: strict FIFO. Writes to the same address are never reordered.
- stall: registered, next value = (count_next >= DEPTH-SKID). It deasserts on the edge after occupancy drops below the threshold.
- Pointers: wrap modulo DEPTH. count is width-extended by one bit to distinguish full from empty.
- FSM states and transitions:
  - IDLE: fb_we=0. Go to DRAIN when count>0.
  - DRAIN: fb_we=1 while count>0. Each pop increments the burst counter.
    - Go to IDLE when the last entry pops with no simultaneous push.
    - Go to YIELD when the burst counter reaches MAX_BURST.
  - YIELD: fb_we=0 for exactly one cycle; burst counter cleared. Go to DRAIN if count>0, else IDLE.
  - fb_ready=0 in DRAIN: fb_we stays 1 and the head holds. Neither the burst counter nor the state changes.

Optional Feature:
- Macro: VGA_WRITE_COALESCE_EN.
- Defined:
  - A push whose wr_addr equals the newest queued entry's address overwrites that entry's data instead of enqueuing.
  - Coalescing does not apply if that entry is also the head being popped in the same cycle; the push then enqueues normally.
  - count is unchanged on a coalesced push.
- Undefined: every accepted push enqueues.

Decomposition:
- Shared package: VGA_ADDR_W=19, VGA_DATA_W=8, the FSM state encoding (IDLE, DRAIN, YIELD), and the packed entry type {addr, data}.
- One sub-module, vga_wbuf_fifo: storage, pointers, count, full/empty.
- The top holds the FSM, burst counter, stall, and overflow logic.

Test Plan:
- Basic path: fb_ready=1; one write addr=0x00010, data=0x3C -> fb_we=1 with fb_addr=0x00010, fb_data=0x3C in the next cycle; count returns to 0; FSM back to IDLE.
- Stall threshold: fb_ready=0; push 6 writes (DEPTH=8, SKID=2) -> stall=1 after the 6th edge; 2 more writes accepted; count=8; overflow=0.
- Overflow: continue with a 9th write while full and fb_ready=0 -> write dropped, overflow=1 and sticky. Then fb_ready=1 -> the 8 writes drain in order; stall falls once count<6.
- Burst yield: fb_ready=1; 20 back-to-back writes -> 16 consecutive fb_we cycles, one fb_we=0 cycle, then the remaining 4; address order preserved.
- Reset mid-drain: reset=0 asynchronously with count=5 -> all outputs 0 immediately, without waiting for a clock edge; no fb_we after release until a new write arrives.
- Coalesce (VGA_WRITE_COALESCE_EN): fb_ready=0; writes addr 0x100 data 0x11, then addr 0x100 data 0x22 -> count=1; the drain yields a single write of 0x22. Without the macro: count=2 and two writes.
